// File: rtl/wb_port_arbiter.sv
// Round-robin writeback port arbiter: picks one requester per cycle and registers its result.
// Optional WB_ARB_X0_DROP_EN: requests to register x0 are accepted and dropped outside arbitration.
module wb_port_arbiter #(
    parameter int embedded = 1,
    parameter int wb_depth = 16,
    parameter int num_req  = 3,
    localparam int raddr_w  = (embedded != 0) ? 4 : 5,
    localparam int wb_tag_w = ($clog2(wb_depth) < 1) ? 1 : $clog2(wb_depth)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         Stall,
    input  logic [num_req-1:0]           ReqValid,
    output logic [num_req-1:0]           ReqReady,
    input  logic [num_req*raddr_w-1:0]   ReqAddr,
    input  logic [num_req*wb_tag_w-1:0]  ReqTag,
    input  logic [num_req*32-1:0]        ReqData,
    output logic [raddr_w-1:0]           WbAddr,
    output logic [wb_tag_w-1:0]          WbTag,
    output logic [31:0]                  WbData,
    output logic                         WbValid
);

    localparam int ptr_w = ($clog2(num_req) < 1) ? 1 : $clog2(num_req);

    logic [ptr_w-1:0]    r_rrPtr;
    logic                r_wbValid;
    logic [raddr_w-1:0]  r_wbAddr;
    logic [wb_tag_w-1:0] r_wbTag;
    logic [31:0]         r_wbData;

    logic                w_open;
    logic [num_req-1:0]  w_arbReq;
    logic [num_req-1:0]  w_dropReady;
    logic [num_req-1:0]  w_grant;
    logic                w_anyGrant;
    logic [ptr_w-1:0]    w_grantIdx;
    logic [ptr_w-1:0]    w_nextPtr;
    logic [raddr_w-1:0]  w_selAddr;
    logic [wb_tag_w-1:0] w_selTag;
    logic [31:0]         w_selData;

    // Nothing is accepted while held in reset or stalled.
    assign w_open = rst & ~Stall;

`ifdef WB_ARB_X0_DROP_EN
    logic [num_req-1:0] w_isX0;

    always_comb begin
        w_isX0 = '0;
        for (int i = 0; i < num_req; i++) begin
            w_isX0[i] = (ReqAddr[i*raddr_w +: raddr_w] == '0);
        end
    end

    assign w_arbReq    = ReqValid & ~w_isX0 & {num_req{w_open}};
    assign w_dropReady = ReqValid &  w_isX0 & {num_req{w_open}};
`else
    assign w_arbReq    = ReqValid & {num_req{w_open}};
    assign w_dropReady = '0;
`endif

    // Search starts at the pointer and wraps; the first eligible requester wins.
    always_comb begin
        int idx;
        w_grant    = '0;
        w_anyGrant = 1'b0;
        w_grantIdx = '0;
        w_selAddr  = '0;
        w_selTag   = '0;
        w_selData  = '0;
        for (int k = 0; k < num_req; k++) begin
            idx = int'(r_rrPtr) + k;
            if (idx >= num_req) begin
                idx = idx - num_req;
            end
            if (!w_anyGrant && w_arbReq[idx]) begin
                w_anyGrant   = 1'b1;
                w_grantIdx   = ptr_w'(idx);
                w_grant[idx] = 1'b1;
                w_selAddr    = ReqAddr[idx*raddr_w +: raddr_w];
                w_selTag     = ReqTag[idx*wb_tag_w +: wb_tag_w];
                w_selData    = ReqData[idx*32 +: 32];
            end
        end
    end

    assign w_nextPtr = (w_grantIdx == ptr_w'(num_req - 1)) ? '0 : w_grantIdx + 1'b1;
    assign ReqReady  = w_grant | w_dropReady;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rrPtr   <= '0;
            r_wbValid <= 1'b0;
            r_wbAddr  <= '0;
            r_wbTag   <= '0;
            r_wbData  <= '0;
        end else if (w_anyGrant) begin
            r_rrPtr   <= w_nextPtr;
            r_wbValid <= 1'b1;
            r_wbAddr  <= w_selAddr;
            r_wbTag   <= w_selTag;
            r_wbData  <= w_selData;
        end else begin
            r_wbValid <= 1'b0;
            r_wbAddr  <= '0;
            r_wbTag   <= '0;
            r_wbData  <= '0;
        end
    end

    assign WbValid = r_wbValid;
    assign WbAddr  = r_wbAddr;
    assign WbTag   = r_wbTag;
    assign WbData  = r_wbData;

endmodule
